// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - Shared types and widths for the SRAM port arbiter
package sram_arb_pkg;

    localparam int OS_ADDR_W = 12;
    localparam int OS_DATA_W = 16;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_A,
        OWN_B
    } owner_t;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// rtl/sram_rd_tag_pipe.sv - Shift register of read tags that follows each read to its data return
module sram_rd_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out,
    output logic    any_valid
);

    rd_tag_t [DEPTH-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], tag_in};
        end
    end

    assign tag_out = stages[DEPTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stages[i].valid;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - Round-robin arbiter with burst lock sharing the on-chip SRAM port
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic                 a_lock,
    input  logic [OS_ADDR_W-1:0] a_addr,
    input  logic [OS_DATA_W-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [OS_DATA_W-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic                 b_lock,
    input  logic [OS_ADDR_W-1:0] b_addr,
    input  logic [OS_DATA_W-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [OS_DATA_W-1:0] b_rdata,
    output logic [OS_ADDR_W-1:0] OSAdd,
    output logic                 OSRead,
    output logic                 OSWrite,
    output logic [OS_DATA_W-1:0] OSDataout,
    input  logic [OS_DATA_W-1:0] OSDatain,
    output logic                 busy
);

    localparam logic [7:0] BURST_CAP = 8'(MAX_BURST);

    owner_t               owner, owner_nxt, winner;
    logic                 last_b, last_b_nxt;
    logic [7:0]           burst_cnt, burst_cnt_nxt;
    logic                 grant_a, grant_b, grant_any;
    logic                 sel_we;
    logic [OS_ADDR_W-1:0] sel_addr;
    logic [OS_DATA_W-1:0] sel_wdata;
    rd_tag_t              tag_in, tag_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_NONE;
            last_b    <= 1'b1;
            burst_cnt <= '0;
        end else begin
            owner     <= owner_nxt;
            last_b    <= last_b_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // Locked owner keeps the port until the cap, but only while the other side waits.
    always_comb begin
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        winner        = OWN_NONE;
        owner_nxt     = owner;
        last_b_nxt    = last_b;
        burst_cnt_nxt = burst_cnt;
        if (!rst) begin
            if (owner == OWN_A && a_req && a_lock && (burst_cnt < BURST_CAP || !b_req)) begin
                grant_a = 1'b1;
            end else if (owner == OWN_B && b_req && b_lock && (burst_cnt < BURST_CAP || !a_req)) begin
                grant_b = 1'b1;
            end else if (a_req && b_req) begin
                grant_a = last_b;
                grant_b = !last_b;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
        if (grant_a || grant_b) begin
            winner     = grant_b ? OWN_B : OWN_A;
            last_b_nxt = grant_b;
            if (winner == owner) begin
                if (burst_cnt < BURST_CAP) begin
                    burst_cnt_nxt = burst_cnt + 8'd1;
                end
            end else begin
                owner_nxt     = winner;
                burst_cnt_nxt = 8'd1;
            end
        end
    end

    assign a_gnt     = grant_a;
    assign b_gnt     = grant_b;
    assign grant_any = grant_a | grant_b;
    assign sel_we    = grant_b ? b_we    : a_we;
    assign sel_addr  = grant_b ? b_addr  : a_addr;
    assign sel_wdata = grant_b ? b_wdata : a_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            OSRead    <= 1'b0;
            OSWrite   <= 1'b0;
            OSAdd     <= '0;
            OSDataout <= '0;
        end else if (grant_any) begin
            OSRead    <= !sel_we;
            OSWrite   <= sel_we;
            OSAdd     <= sel_addr;
            OSDataout <= sel_wdata;
        end else begin
            OSRead  <= 1'b0;
            OSWrite <= 1'b0;
        end
    end

    assign tag_in.valid = grant_any && !sel_we;
    assign tag_in.port  = grant_b;

    // The tag reaches the last stage in the cycle OSDatain carries its data.
    sram_rd_tag_pipe #(
        .DEPTH(READ_LAT + 1)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .tag_in   (tag_in),
        .tag_out  (tag_out),
        .any_valid(busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= tag_out.valid && tag_out.port == PORT_A;
            b_rvalid <= tag_out.valid && tag_out.port == PORT_B;
            if (tag_out.valid && tag_out.port == PORT_A) begin
                a_rdata <= OSDatain;
            end
            if (tag_out.valid && tag_out.port == PORT_B) begin
                b_rdata <= OSDatain;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - Self-checking bench for sram_port_arbiter against a transaction-level model
module tb_sram_port_arbiter;

    localparam int RL = 3;
    localparam int MB = 16;

    logic        clk;
    logic        rst;
    logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [11:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic [11:0] OSAdd;
    logic        OSRead, OSWrite;
    logic [15:0] OSDataout, OSDatain;
    logic        busy;

    sram_port_arbiter #(.READ_LAT(RL), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .OSAdd(OSAdd), .OSRead(OSRead), .OSWrite(OSWrite), .OSDataout(OSDataout),
        .OSDatain(OSDatain), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] init_val(input int i);
        if (i == 16) return 16'hBEEF;
        return 16'(i * 4951 + 9);
    endfunction

    // SRAM behaviour: data appears RL cycles after the read strobe, garbage otherwise.
    logic        mem_init;
    logic [15:0] smem [64];
    logic [15:0] sdly [RL];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) smem[i] <= init_val(i);
        end else if (OSWrite) begin
            smem[OSAdd[5:0]] <= OSDataout;
        end
        sdly[0] <= OSRead ? smem[OSAdd[5:0]] : 16'($urandom);
        for (int k = 1; k < RL; k++) sdly[k] <= sdly[k-1];
    end
    assign OSDatain = sdly[RL-1];

    typedef struct {
        bit          we;
        bit          lock;
        logic [11:0] addr;
        logic [15:0] wdata;
        int          start;
    } op_t;

    typedef struct {
        int          due;
        bit          port;
        logic [15:0] data;
    } ret_t;

    op_t         qa[$], qb[$];
    ret_t        sb[$];
    int          g_port[$], g_cyc[$], r_port[$], r_cyc[$];
    logic [15:0] r_data[$];
    logic [15:0] rmem [64];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          eg = 0;
    int          m_owner = 0;
    int          m_last = 2;
    int          m_cnt = 0;
    bit          armed = 0;
    bit          after_rst = 0;
    logic        e_rd = 0, e_wr = 0;
    logic [11:0] e_add = '0;
    logic [15:0] e_dout = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant decision: 0 none, 1 A, 2 B.
    function automatic int arb();
        if (rst) return 0;
        if (m_owner == 1 && a_req && a_lock && (m_cnt < MB || !b_req)) return 1;
        if (m_owner == 2 && b_req && b_lock && (m_cnt < MB || !a_req)) return 2;
        if (a_req && b_req) return (m_last == 1) ? 2 : 1;
        if (a_req) return 1;
        if (b_req) return 2;
        return 0;
    endfunction

    task automatic drive();
        if (qa.size() > 0 && qa[0].start <= cyc) begin
            a_req = 1'b1; a_we = qa[0].we; a_lock = qa[0].lock;
            a_addr = qa[0].addr; a_wdata = qa[0].wdata;
        end else begin
            a_req = 1'b0; a_we = 1'($urandom); a_lock = 1'b0;
            a_addr = 12'($urandom); a_wdata = 16'($urandom);
        end
        if (qb.size() > 0 && qb[0].start <= cyc) begin
            b_req = 1'b1; b_we = qb[0].we; b_lock = qb[0].lock;
            b_addr = qb[0].addr; b_wdata = qb[0].wdata;
        end else begin
            b_req = 1'b0; b_we = 1'($urandom); b_lock = 1'b0;
            b_addr = 12'($urandom); b_wdata = 16'($urandom);
        end
    endtask

    task automatic model_update();
        op_t op;
        if (rst) begin
            m_owner = 0; m_last = 2; m_cnt = 0;
            e_rd = 1'b0; e_wr = 1'b0; e_add = '0; e_dout = '0;
            sb.delete();
            armed = 1; after_rst = 1;
        end else begin
            after_rst = 0;
            if (eg != 0) begin
                if (eg == 1) begin op = qa[0]; void'(qa.pop_front()); end
                else begin op = qb[0]; void'(qb.pop_front()); end
                m_last = eg;
                if (eg == m_owner) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                else begin m_owner = eg; m_cnt = 1; end
                e_rd = !op.we; e_wr = op.we; e_add = op.addr; e_dout = op.wdata;
                if (op.we) rmem[op.addr[5:0]] = op.wdata;
                else sb.push_back('{due: cyc + RL + 2, port: (eg == 2), data: rmem[op.addr[5:0]]});
            end else begin
                e_rd = 1'b0; e_wr = 1'b0;
            end
        end
    endtask

    task automatic tick();
        bit exp_busy;
        @(negedge clk);
        eg = arb();
        if (armed) begin
            chk("a_gnt", 32'(a_gnt), 32'(eg == 1));
            chk("b_gnt", 32'(b_gnt), 32'(eg == 2));
            chk("OSRead", 32'(OSRead), 32'(e_rd));
            chk("OSWrite", 32'(OSWrite), 32'(e_wr));
            chk("OSAdd", 32'(OSAdd), 32'(e_add));
            chk("OSDataout", 32'(OSDataout), 32'(e_dout));
            exp_busy = 0;
            foreach (sb[i]) if (sb[i].due > cyc) exp_busy = 1;
            chk("busy", 32'(busy), 32'(exp_busy));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("a_rvalid", 32'(a_rvalid), 32'(!sb[0].port));
                chk("b_rvalid", 32'(b_rvalid), 32'(sb[0].port));
                if (sb[0].port) chk("b_rdata", 32'(b_rdata), 32'(sb[0].data));
                else chk("a_rdata", 32'(a_rdata), 32'(sb[0].data));
                void'(sb.pop_front());
            end else begin
                chk("a_rvalid_idle", 32'(a_rvalid), 32'(0));
                chk("b_rvalid_idle", 32'(b_rvalid), 32'(0));
            end
            if (after_rst) begin
                chk("a_rdata_rst", 32'(a_rdata), 32'(0));
                chk("b_rdata_rst", 32'(b_rdata), 32'(0));
            end
        end
        if (a_gnt === 1'b1) begin g_port.push_back(0); g_cyc.push_back(cyc); end
        if (b_gnt === 1'b1) begin g_port.push_back(1); g_cyc.push_back(cyc); end
        if (a_rvalid === 1'b1) begin r_port.push_back(0); r_cyc.push_back(cyc); r_data.push_back(a_rdata); end
        if (b_rvalid === 1'b1) begin r_port.push_back(1); r_cyc.push_back(cyc); r_data.push_back(b_rdata); end
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        drive();
    endtask

    task automatic add_op(input bit port, input bit we, input bit lock,
                          input logic [11:0] addr, input logic [15:0] wdata, input int start);
        if (port) qb.push_back('{we: we, lock: lock, addr: addr, wdata: wdata, start: start});
        else qa.push_back('{we: we, lock: lock, addr: addr, wdata: wdata, start: start});
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        drive();
        while ((qa.size() > 0 || qb.size() > 0 || sb.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 32'(qa.size() + qb.size() + sb.size()), 32'(0));
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive();
        tick();
        rst = 1'b0;
        g_port.delete(); g_cyc.delete(); r_port.delete(); r_cyc.delete(); r_data.delete();
    endtask

    task automatic rand_batch(input int na, input int nb, input int lock_pct,
                              input int gap_a, input int gap_b);
        int sa, sbt;
        sa = cyc; sbt = cyc;
        for (int i = 0; i < na; i++) begin
            sa += $urandom_range(gap_a, 0);
            add_op(0, 1'($urandom), ($urandom_range(99, 0) < lock_pct), 12'($urandom), 16'($urandom), sa);
        end
        for (int i = 0; i < nb; i++) begin
            sbt += $urandom_range(gap_b, 0);
            add_op(1, 1'($urandom), ($urandom_range(99, 0) < 30), 12'($urandom), 16'($urandom), sbt);
        end
    endtask

    initial begin
        int t0, n_reads, n_arv;
        for (int i = 0; i < 64; i++) rmem[i] = init_val(i);
        mem_init = 1'b1;
        rst = 1'b1;
        drive();
        tick();
        tick();
        rst = 1'b0;
        mem_init = 1'b0;

        // Single A read returning the preloaded word.
        add_op(0, 0, 0, 12'h010, 16'h0000, cyc);
        run_idle(100);
        chk("t1_ngnt", 32'(g_port.size()), 32'(1));
        chk("t1_gport", 32'(g_port[0]), 32'(0));
        chk("t1_nrv", 32'(r_port.size()), 32'(1));
        chk("t1_rvport", 32'(r_port[0]), 32'(0));
        chk("t1_rvlat", 32'(r_cyc[0] - g_cyc[0]), 32'(RL + 2));
        chk("t1_rdata", 32'(r_data[0]), 32'(16'hBEEF));

        // Both ports requesting without lock alternate starting with A.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            add_op(0, 1'(i), 0, 12'($urandom), 16'($urandom), cyc);
            add_op(1, 1'(i + 1), 0, 12'($urandom), 16'($urandom), cyc);
        end
        run_idle(200);
        chk("t2_ngnt", 32'(g_port.size()), 32'(6));
        for (int i = 0; i < 6; i++) begin
            chk("t2_order", 32'(g_port[i]), 32'(i % 2));
            chk("t2_nobubble", 32'(g_cyc[i] - g_cyc[0]), 32'(i));
        end

        // Locked A burst hits the cap while B waits.
        do_reset();
        for (int i = 0; i < 20; i++) add_op(0, 1, 1, 12'(i), 16'($urandom), cyc);
        add_op(1, 1, 0, 12'h7FF, 16'h1234, cyc);
        run_idle(200);
        chk("t3_ngnt", 32'(g_port.size()), 32'(21));
        for (int i = 0; i < 21; i++) begin
            chk("t3_order", 32'(g_port[i]), 32'(i == 16));
            chk("t3_nobubble", 32'(g_cyc[i] - g_cyc[0]), 32'(i));
        end

        // Locked A burst with B idle keeps the port.
        do_reset();
        for (int i = 0; i < 20; i++) add_op(0, 1, 1, 12'(i + 100), 16'($urandom), cyc);
        run_idle(200);
        chk("t4_ngnt", 32'(g_port.size()), 32'(20));
        for (int i = 0; i < 20; i++) begin
            chk("t4_owner", 32'(g_port[i]), 32'(0));
            chk("t4_nobubble", 32'(g_cyc[i] - g_cyc[0]), 32'(i));
        end

        // Interleaved reads A, B, A return in order with fixed latency.
        do_reset();
        add_op(0, 0, 0, 12'h021, 16'h0, cyc + 1);
        add_op(1, 0, 0, 12'h022, 16'h0, cyc + 2);
        add_op(0, 0, 0, 12'h023, 16'h0, cyc + 3);
        run_idle(200);
        chk("t5_nrv", 32'(r_port.size()), 32'(3));
        for (int i = 0; i < 3; i++) begin
            chk("t5_rvorder", 32'(r_port[i]), 32'(i == 1));
            chk("t5_rvlat", 32'(r_cyc[i] - g_cyc[i]), 32'(RL + 2));
        end

        // Reset with a read in flight drops it; held B request wins right after.
        do_reset();
        t0 = cyc;
        add_op(0, 0, 0, 12'h030, 16'h0, cyc);
        drive();
        tick();
        tick();
        add_op(1, 1, 0, 12'h031, 16'h5555, cyc);
        rst = 1'b1;
        drive();
        tick();
        rst = 1'b0;
        run_idle(200);
        n_arv = 0;
        foreach (r_port[i]) if (r_port[i] == 0) n_arv++;
        chk("t6_no_arvalid", 32'(n_arv), 32'(0));
        chk("t6_ngnt", 32'(g_port.size()), 32'(2));
        chk("t6_bport", 32'(g_port[1]), 32'(1));
        chk("t6_bcyc", 32'(g_cyc[1] - t0), 32'(3));

        // Random mixed traffic, then a lock-heavy A stream against sparse B.
        do_reset();
        rand_batch(60, 60, 40, 3, 3);
        n_reads = 0;
        foreach (qa[i]) if (!qa[i].we) n_reads++;
        foreach (qb[i]) if (!qb[i].we) n_reads++;
        run_idle(3000);
        chk("rnd1_ngnt", 32'(g_port.size()), 32'(120));
        chk("rnd1_nrv", 32'(r_port.size()), 32'(n_reads));

        do_reset();
        rand_batch(60, 12, 90, 0, 8);
        run_idle(3000);
        chk("rnd2_ngnt", 32'(g_port.size()), 32'(72));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
